led_pio_write_arbiter: RTL and testbench

//  Shares one 18-bit LED PIO Avalon-MM slave (data reg at address 0, combinational readdata, no waitrequest)

---
 rtl/led_pio_pkg.sv | 28 ++
 rtl/led_pio_write_arbiter_rr.sv | 26 ++
 rtl/led_pio_write_arbiter.sv | 106 ++++++++++
 tb/tb_led_pio_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared constants, state encoding and pointer helper for the LED PIO
// write arbiter.
package led_pio_pkg;

   localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
   localparam int         LED_PIO_W     = 18;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WRITE  = 2'd1;
   localparam logic [1:0] ST_VERIFY = 2'd2;
   localparam logic [1:0] ST_ACK    = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      WRITE  = ST_WRITE,
      VERIFY = ST_VERIFY,
      ACK    = ST_ACK
   } state_e;

   function automatic logic [2:0] rr_next(
      input logic [2:0] w,
      input int         n
   );
      if (int'(w) >= n - 1) return 3'd0;
      return w + 3'd1;
   endfunction

endpackage

// File: rtl/led_pio_write_arbiter_rr.sv
// Combinational round-robin winner search starting at the pointer,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic [2:0]      winner,
   output logic            any_req
);

   int idx;

   // Walk downward so the candidate closest to ptr is assigned last.
   always_comb begin
      winner  = '0;
      any_req = |req;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) winner = 3'(idx);
      end
   end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Round-robin sharing of one LED PIO data register among NREQ writers,
// with optional read-back verification and a sticky error flag.
module led_pio_write_arbiter
   import led_pio_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int PIO_W     = LED_PIO_W,
   parameter int VERIFY_EN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*PIO_W-1:0] req_data,
   output logic [NREQ-1:0]       ack,
   output logic                  busy,
   output logic [2:0]            grant_idx,
   output logic [1:0]            avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write_n,
   output logic [31:0]           avm_writedata,
   input  logic [31:0]           avm_readdata,
   output logic                  verify_err,
   input  logic                  err_clear
);

   state_e             state_q, state_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         grant_q, grant_d;
   logic [PIO_W-1:0]   data_q, data_d;
   logic               err_q, err_d;
   logic [2:0]         winner;
   logic               any_req;
   logic               mismatch;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Bus drive depends only on registered state, never on req.
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      grant_d        = grant_q;
      data_d         = data_q;
      err_d          = err_q;
      mismatch       = 1'b0;
      ack            = '0;
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_writedata  = '0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               data_d  = req_data[int'(winner)*PIO_W +: PIO_W];
               ptr_d   = rr_next(winner, NREQ);
               state_d = WRITE;
            end
         end
         WRITE: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_writedata  = {{(32-PIO_W){1'b0}}, data_q};
            state_d        = (VERIFY_EN != 0) ? VERIFY : ACK;
         end
         VERIFY: begin
            avm_chipselect = 1'b1;
            mismatch = (avm_readdata[PIO_W-1:0] != data_q) ||
                       (|avm_readdata[31:PIO_W]);
            state_d  = ACK;
         end
         ACK: begin
            for (int i = 0; i < NREQ; i++)
               ack[i] = (grant_q == 3'(i));
            state_d = IDLE;
         end
      endcase
      if (err_clear) err_d = 1'b0;
      if (mismatch)  err_d = 1'b1;
   end

   assign avm_address = PIO_DATA_ADDR;
   assign busy        = (state_q != IDLE);
   assign grant_idx   = grant_q;
   assign verify_err  = err_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench for the LED PIO write arbiter: one verifying instance
// against an echoing PIO model, one instance with verify disabled.
module tb_led_pio_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [71:0] req_data;
   logic [3:0]  ack;
   logic        busy;
   logic [2:0]  grant_idx;
   logic [1:0]  avm_address;
   logic        cs;
   logic        wn;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        verify_err;
   logic        err_clear;

   logic [3:0]  req_b;
   logic [71:0] req_data_b;
   logic [3:0]  ack_b;
   logic        busy_b;
   logic [2:0]  grant_idx_b;
   logic [1:0]  avm_address_b;
   logic        cs_b;
   logic        wn_b;
   logic [31:0] wd_b;
   logic        verify_err_b;

   logic [17:0] pio_q;
   logic        ovr;
   logic [31:0] ovr_val;
   int          rd_strobe_b;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   led_pio_write_arbiter #(.NREQ(4), .PIO_W(18), .VERIFY_EN(1)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .req_data       (req_data),
      .ack            (ack),
      .busy           (busy),
      .grant_idx      (grant_idx),
      .avm_address    (avm_address),
      .avm_chipselect (cs),
      .avm_write_n    (wn),
      .avm_writedata  (wd),
      .avm_readdata   (rd),
      .verify_err     (verify_err),
      .err_clear      (err_clear)
   );

   led_pio_write_arbiter #(.NREQ(4), .PIO_W(18), .VERIFY_EN(0)) u_dut_nv (
      .clk            (clk),
      .reset          (reset),
      .req            (req_b),
      .req_data       (req_data_b),
      .ack            (ack_b),
      .busy           (busy_b),
      .grant_idx      (grant_idx_b),
      .avm_address    (avm_address_b),
      .avm_chipselect (cs_b),
      .avm_write_n    (wn_b),
      .avm_writedata  (wd_b),
      .avm_readdata   (32'h0),
      .verify_err     (verify_err_b),
      .err_clear      (1'b0)
   );

   // PIO slave model: data register with combinational read-back.
   always @(posedge clk)
      if (cs && !wn) pio_q <= wd[17:0];

   assign rd = ovr ? ovr_val : {14'b0, pio_q};

   always @(posedge clk)
      if (cs_b && wn_b) rd_strobe_b <= rd_strobe_b + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [17:0] d);
      req_data[i*18 +: 18] = d;
   endtask

   // Starts in an IDLE cycle, returns in the IDLE cycle after ACK.
   task automatic run_one(input logic [3:0] mask, input int idx,
                          input logic [17:0] d, input bit clr);
      logic [3:0] one;
      one = 4'b0001 << idx;
      set_data(idx, d);
      req = mask;
      tick;
      chk("wr_grant", {29'b0, grant_idx}, idx);
      chk("wr_strobe", {30'b0, cs, wn}, 32'b10);
      chk("wr_data", wd, {14'b0, d});
      tick;
      chk("vf_strobe", {30'b0, cs, wn}, 32'b11);
      if (clr) err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      chk("ack", {28'b0, ack}, {28'b0, one});
      chk("ack_cs", {31'b0, cs}, 32'd0);
      req = '0;
      tick;
      chk("idle_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      req        = '0;
      req_data   = '0;
      err_clear  = 1'b0;
      req_b      = '0;
      req_data_b = '0;
      ovr        = 1'b0;
      ovr_val    = '0;
      pio_q      = '0;
      rd_strobe_b = 0;
      tick;
      chk("rst_ack", {28'b0, ack}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_grant", {29'b0, grant_idx}, 32'd0);
      chk("rst_cs_wn", {30'b0, cs, wn}, 32'b01);
      chk("rst_addr", {30'b0, avm_address}, 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_err", {31'b0, verify_err}, 32'd0);
      reset = 1'b0;
      tick;

      // Single write with echo, ack in cycle 3.
      run_one(4'b0100, 2, 18'h2A5A5, 1'b0);
      chk("t1_err", {31'b0, verify_err}, 32'd0);

      // All four held: grants 0,1,2,3,0 every 4 cycles.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_data(i, 18'h1000 + 18'(i));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("rr_grant", {29'b0, grant_idx}, k % 4);
         chk("rr_wd", wd, 32'h1000 + (k % 4));
         tick;
         tick;
         chk("rr_ack", {28'b0, ack}, 32'd1 << (k % 4));
         if (k == 4) req = '0;
         tick;
         chk("rr_idle", {31'b0, busy}, 32'd0);
      end

      // Bad read-back sets error; clear loses to a simultaneous set.
      ovr     = 1'b1;
      ovr_val = 32'h00040000;
      run_one(4'b0010, 1, 18'h00000, 1'b0);
      chk("t3_set", {31'b0, verify_err}, 32'd1);
      run_one(4'b0010, 1, 18'h00000, 1'b1);
      chk("t3_setwins", {31'b0, verify_err}, 32'd1);
      ovr = 1'b0;
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      chk("t3_clear", {31'b0, verify_err}, 32'd0);

      // Reset during VERIFY aborts; pointer returns to 0.
      set_data(2, 18'h0BEEF);
      req = 4'b0100;
      tick;
      tick;
      chk("t4_in_vf", {30'b0, cs, wn}, 32'b11);
      #2;
      reset = 1'b1;
      #1;
      chk("t4_cs_wn", {30'b0, cs, wn}, 32'b01);
      chk("t4_ack", {28'b0, ack}, 32'd0);
      chk("t4_busy", {31'b0, busy}, 32'd0);
      tick;
      chk("t4_ack_hold", {28'b0, ack}, 32'd0);
      reset = 1'b0;
      req   = '0;
      set_data(3, 18'h33333);
      run_one(4'b1010, 1, 18'h11111, 1'b0);

      // Drop after grant still acks; drop before grant withdraws.
      set_data(3, 18'h3C3C3);
      req = 4'b1000;
      tick;
      chk("t5_grant", {29'b0, grant_idx}, 32'd3);
      req = 4'b0010;
      tick;
      tick;
      chk("t5_ack", {28'b0, ack}, 32'h8);
      req = '0;
      tick;
      chk("t5_idle", {31'b0, busy}, 32'd0);
      tick;
      chk("t5_nogrant", {30'b0, busy, 1'b0} | {29'b0, grant_idx}, 32'd3);

      // Verify disabled: ack in cycle 2, no read strobe.
      req_data_b[17:0] = 18'h3FFFF;
      req_b = 4'b0001;
      tick;
      chk("nv_wd", wd_b, 32'h0003FFFF);
      chk("nv_strobe", {30'b0, cs_b, wn_b}, 32'b10);
      tick;
      chk("nv_ack", {28'b0, ack_b}, 32'h1);
      req_b = '0;
      tick;
      chk("nv_idle", {31'b0, busy_b}, 32'd0);
      tick;
      chk("nv_no_read", rd_strobe_b, 32'd0);
      chk("nv_err", {31'b0, verify_err_b}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
